data_mem_bridge: RTL and testbench
==================================

DATA_MEM_BRIDGE -- requirements
Module: data_mem_bridge

Interface
REQ-001 SHALL have parameter RAM_AW, default 14, meaning RAM word-address width (64 KiB).
REQ-002 SHALL have parameter IO_TIMEOUT, default 255, meaning the maximum cycles to wait for io_ack.
REQ-003 SHALL have these ports:
- clk  in  1  clock, single domain; reset is asynchronous and active-high (rst).
- rst  in  1  asynchronous active-high reset.
- mem_addr  in  32  byte address from the core.
- mem_oe  in  4  low-justified byte-lane access mask: 0001, 0011 or 1111.
- mem_wdata  in  32  low-justified store data.
- mem_we  in  4  low-justified store mask; nonzero means store.
- mem_rdata  out  32  low-justified load data.
- mem_valid  out  1  one-cycle load-data strobe.
- mem_ready  out  1  bridge can accept a request this cycle.
- ram_addr  out  RAM_AW  word address.
- ram_en  out  1  RAM enable.
- ram_we  out  4  RAM byte write enables.
- ram_wdata  out  32  lane-aligned write data.
- ram_rdata  in  32  RAM read data, 1-cycle latency.
- io_req  out  1  peripheral request, held until io_ack.
- io_we  out  4  lane-aligned peripheral byte write enables.
- io_addr  out  32  full byte address.
- io_wdata  out  32  lane-aligned peripheral write data.
- io_ack  in  1  peripheral completion, one cycle.
- io_rdata  in  32  peripheral read data, valid with io_ack.
- err  out  1  sticky error flag.

Function
REQ-004 SHALL accept a request in any cycle where mem_ready=1 and mem_oe!=0; requests when mem_ready=0 SHALL be ignored.
REQ-005 SHALL decode mem_addr[31:28]==4'h8 as IO and every other value as RAM.
REQ-006 SHALL shift mem_we and mem_wdata left by mem_addr[1:0] bytes, and SHALL shift read data right by the latched addr[1:0] bytes into mem_rdata[7:0] or [15:0]; upper bytes SHALL be zero (sign extension is done by the core).
REQ-007 SHALL treat as misaligned: a halfword with addr[0]=1, or a word with addr[1:0]!=0; a misaligned access SHALL issue no RAM or IO access, SHALL set err, and, if a load, SHALL pulse mem_valid next cycle with mem_rdata=0.
REQ-008 SHALL use states IDLE, RAM_RD, IO_WAIT, IO_RESP; mem_ready=1 only in IDLE.
REQ-009 RAM store: in the accepting cycle, SHALL drive ram_en=1, ram_we=aligned mask and ram_addr=mem_addr[RAM_AW+1:2] combinationally, and SHALL remain in IDLE with no mem_valid.
REQ-010 RAM load: SHALL drive ram_en=1 and ram_we=0 in the accepting cycle and go to RAM_RD; in RAM_RD, SHALL output mem_valid=1 and mem_rdata=aligned ram_rdata combinationally, then return to IDLE.
REQ-011 IO access: SHALL register io_req=1, io_addr, io_we and io_wdata at the accept edge, enter IO_WAIT, and hold all four stable until io_ack.
REQ-012 On io_ack in IO_WAIT: SHALL drop io_req next cycle; a load SHALL go to IO_RESP (registered mem_valid=1, aligned io_rdata) and then IDLE; a store SHALL go directly to IDLE.
REQ-013 IO_WAIT SHALL count cycles from 0; when the count reaches IO_TIMEOUT without io_ack, SHALL drop io_req, set err, and for a load return mem_rdata=32'hDEADBEEF via IO_RESP.
REQ-014 io_ack in the same cycle the count reaches IO_TIMEOUT SHALL be treated as success; io_ack outside IO_WAIT SHALL be ignored.
REQ-015 mem_valid SHALL be exactly one cycle per accepted load and never asserted for stores.
REQ-016 err SHALL be sticky until rst.

Reset
REQ-017 rst SHALL asynchronously force state=IDLE, io_req=0, io_we=0, io_addr=0, io_wdata=0, mem_valid=0, mem_rdata=0, err=0 and the timeout count=0; mem_ready SHALL be 1 after reset.
REQ-018 rst asserted mid-transaction SHALL abandon the transaction with no mem_valid; ram_en and ram_we SHALL be 0 while rst=1.

Structure
REQ-019 A shared package SHALL hold the state encoding, the IO region nibble 4'h8 and the timeout data constant 32'hDEADBEEF.
REQ-020 Lane shifting and misalignment detection SHALL live in one combinational sub-module, mem_lane_align, instantiated for the write path and reused for the read path.

Verification
REQ-021 SW 0x11223344 to addr 0x100, then LW 0x100 -> ram_we=1111 at word 0x40; mem_valid exactly one cycle after the LW accept, with mem_rdata=0x11223344.
REQ-022 SB wdata 0x000000AB to addr 0x103, then LBU 0x103 -> ram_we=1000 and ram_wdata[31:24]=0xAB; load returns mem_rdata=0x000000AB.
REQ-023 LW 0x80000004 with io_ack after 5 cycles and io_rdata=0xCAFEF00D -> mem_ready=0 throughout; mem_valid one cycle after ack with 0xCAFEF00D; io_req low after ack.
REQ-024 LW 0x80000008 with no io_ack -> io_req drops after 255 cycles; mem_valid with 0xDEADBEEF; err=1 and stays 1.
REQ-025 LH at addr 0x101 -> no ram_en; err=1; mem_valid next cycle with mem_rdata=0.
REQ-026 rst pulsed during IO_WAIT -> io_req=0 and mem_ready=1 immediately; no mem_valid; err=0.

Source files
------------

// File: rtl/data_mem_bridge_pkg.sv
// Shared definitions for the core-to-memory bridge: FSM encoding, the IO region
// nibble, the data returned on peripheral timeout, and a lane-mask helper.
package data_mem_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAM_RD  = 2'd1,
        IO_WAIT = 2'd2,
        IO_RESP = 2'd3
    } state_t;

    localparam logic [3:0]  IO_REGION    = 4'h8;
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

    // Expands a 4-bit byte-lane mask into a 32-bit bit mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] lanes);
        return {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane shifter and misalignment detector. READ=0 shifts store data/mask up
// to the addressed lanes; READ=1 shifts load data down to bit 0.
module mem_lane_align
    import data_mem_bridge_pkg::*;
#(
    parameter bit READ = 1'b0
) (
    input  logic [1:0]  offset,
    input  logic [3:0]  size,
    input  logic [3:0]  lanes_in,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic [3:0]  lanes_out,
    output logic        misaligned
);

    assign misaligned = ((size == 4'b0011) && offset[0]) ||
                        ((size == 4'b1111) && (offset != 2'b00));

    generate
        if (READ) begin : g_rd
            assign data_out  = data_in >> {offset, 3'b000};
            assign lanes_out = lanes_in;
        end else begin : g_wr
            assign data_out  = data_in << {offset, 3'b000};
            assign lanes_out = lanes_in << offset;
        end
    endgenerate

endmodule

// File: rtl/data_mem_bridge.sv
// Bridges core load/store requests to a 1-cycle-latency block RAM or to a
// handshaked peripheral bus (region 0x8xxxxxxx) with timeout and sticky error.
module data_mem_bridge
    import data_mem_bridge_pkg::*;
#(
    parameter int RAM_AW     = 14,
    parameter int IO_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       mem_addr,
    input  logic [3:0]        mem_oe,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_we,
    output logic [31:0]       mem_rdata,
    output logic              mem_valid,
    output logic              mem_ready,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              io_req,
    output logic [3:0]        io_we,
    output logic [31:0]       io_addr,
    output logic [31:0]       io_wdata,
    input  logic              io_ack,
    input  logic [31:0]       io_rdata,
    output logic              err
);

    localparam int CW = $clog2(IO_TIMEOUT + 1);

    state_t        state;
    logic [CW-1:0] count;
    logic [1:0]    lat_offset;
    logic [3:0]    lat_oe;
    logic          lat_load;
    logic          valid_reg;
    logic [31:0]   rdata_reg;

    logic [31:0] wr_data, rd_raw, rd_data, rd_aligned;
    logic [3:0]  wr_lanes, rd_lanes;
    logic        wr_mis, rd_mis;
    logic        accept, is_store, is_io, ram_go;

    mem_lane_align #(.READ(1'b0)) u_wr_align (
        .offset    (mem_addr[1:0]),
        .size      (mem_oe),
        .lanes_in  (mem_we),
        .data_in   (mem_wdata),
        .data_out  (wr_data),
        .lanes_out (wr_lanes),
        .misaligned(wr_mis)
    );

    // Read path reuses the aligner with the offset/size latched at accept.
    assign rd_raw = (state == RAM_RD) ? ram_rdata : io_rdata;

    mem_lane_align #(.READ(1'b1)) u_rd_align (
        .offset    (lat_offset),
        .size      (lat_oe),
        .lanes_in  (lat_oe),
        .data_in   (rd_raw),
        .data_out  (rd_data),
        .lanes_out (rd_lanes),
        .misaligned(rd_mis)
    );

    assign rd_aligned = rd_mis ? 32'h0 : (rd_data & lane_mask(rd_lanes));

    assign accept   = (state == IDLE) && (mem_oe != 4'b0000);
    assign is_store = (mem_we != 4'b0000);
    assign is_io    = (mem_addr[31:28] == IO_REGION);
    assign ram_go   = accept && !wr_mis && !is_io && !rst;

    assign ram_en    = ram_go;
    assign ram_we    = (ram_go && is_store) ? wr_lanes : 4'b0000;
    assign ram_addr  = mem_addr[RAM_AW+1:2];
    assign ram_wdata = wr_data;

    assign mem_ready = (state == IDLE);
    assign mem_valid = (state == RAM_RD) || valid_reg;
    assign mem_rdata = (state == RAM_RD) ? rd_aligned : rdata_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            lat_offset <= 2'b00;
            lat_oe     <= 4'b0000;
            lat_load   <= 1'b0;
            valid_reg  <= 1'b0;
            rdata_reg  <= 32'h0;
            io_req     <= 1'b0;
            io_we      <= 4'b0000;
            io_addr    <= 32'h0;
            io_wdata   <= 32'h0;
            err        <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_offset <= mem_addr[1:0];
                        lat_oe     <= mem_oe;
                        lat_load   <= !is_store;
                        if (wr_mis) begin
                            err <= 1'b1;
                            if (!is_store) begin
                                valid_reg <= 1'b1;
                                rdata_reg <= 32'h0;
                            end
                        end else if (is_io) begin
                            io_req   <= 1'b1;
                            io_addr  <= mem_addr;
                            io_we    <= is_store ? wr_lanes : 4'b0000;
                            io_wdata <= wr_data;
                            count    <= '0;
                            state    <= IO_WAIT;
                        end else if (!is_store) begin
                            state <= RAM_RD;
                        end
                    end
                end
                RAM_RD: state <= IDLE;
                IO_WAIT: begin
                    // An ack on the final count still wins over the timeout.
                    if (io_ack) begin
                        io_req <= 1'b0;
                        if (lat_load) begin
                            valid_reg <= 1'b1;
                            rdata_reg <= rd_aligned;
                            state     <= IO_RESP;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (count == CW'(IO_TIMEOUT)) begin
                        io_req <= 1'b0;
                        err    <= 1'b1;
                        if (lat_load) begin
                            valid_reg <= 1'b1;
                            rdata_reg <= TIMEOUT_DATA;
                            state     <= IO_RESP;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                IO_RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_bridge.sv
// Directed bench for data_mem_bridge: table of RAM load/store vectors plus
// hand-written IO handshake, timeout, boundary-ack and mid-transaction reset sequences.
module tb_data_mem_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_addr = 32'h0;
    logic [3:0]  mem_oe = 4'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [3:0]  mem_we = 4'h0;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic        mem_ready;
    logic [13:0] ram_addr;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'h0;
    logic        io_req;
    logic [3:0]  io_we;
    logic [31:0] io_addr;
    logic [31:0] io_wdata;
    logic        io_ack = 1'b0;
    logic [31:0] io_rdata = 32'h0;
    logic        err;

    always #5 clk = ~clk;

    data_mem_bridge #(.RAM_AW(14), .IO_TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .mem_addr(mem_addr), .mem_oe(mem_oe), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .ram_addr(ram_addr), .ram_en(ram_en), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_ack(io_ack), .io_rdata(io_rdata), .err(err)
    );

    // Behavioural RAM with one-cycle read latency.
    logic [31:0] ram_mem [0:16383];
    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) ram_mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
            ram_rdata <= ram_mem[ram_addr];
        end
    end

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [3:0] oe, input logic [3:0] we,
                         input logic [31:0] wd);
        mem_addr = a; mem_oe = oe; mem_we = we; mem_wdata = wd;
    endtask

    task automatic idle_inputs();
        mem_oe = 4'h0; mem_we = 4'h0; mem_wdata = 32'h0;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  oe;
        logic [3:0]  we;
        logic [31:0] wdata;
        logic        exp_en;
        logic [3:0]  exp_we;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[11];
    int   n;
    int   hi;

    initial begin
        vecs[0]  = '{32'h100, 4'hF, 4'hF, 32'h11223344, 1'b1, 4'hF, 32'h11223344, 32'h0,        1'b0};
        vecs[1]  = '{32'h100, 4'hF, 4'h0, 32'h0,        1'b1, 4'h0, 32'h0,        32'h11223344, 1'b0};
        vecs[2]  = '{32'h103, 4'h1, 4'h1, 32'h000000AB, 1'b1, 4'h8, 32'hAB000000, 32'h0,        1'b0};
        vecs[3]  = '{32'h103, 4'h1, 4'h0, 32'h0,        1'b1, 4'h0, 32'h0,        32'h000000AB, 1'b0};
        vecs[4]  = '{32'h100, 4'hF, 4'h0, 32'h0,        1'b1, 4'h0, 32'h0,        32'hAB223344, 1'b0};
        vecs[5]  = '{32'h202, 4'h3, 4'h3, 32'h0000BEEF, 1'b1, 4'hC, 32'hBEEF0000, 32'h0,        1'b0};
        vecs[6]  = '{32'h202, 4'h3, 4'h0, 32'h0,        1'b1, 4'h0, 32'h0,        32'h0000BEEF, 1'b0};
        vecs[7]  = '{32'h101, 4'h1, 4'h0, 32'h0,        1'b1, 4'h0, 32'h0,        32'h00000033, 1'b0};
        vecs[8]  = '{32'h100, 4'h3, 4'h0, 32'h0,        1'b1, 4'h0, 32'h0,        32'h00003344, 1'b0};
        vecs[9]  = '{32'h101, 4'h3, 4'h0, 32'h0,        1'b0, 4'h0, 32'h0,        32'h0,        1'b1};
        vecs[10] = '{32'h102, 4'hF, 4'hF, 32'h12345678, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1};

        // Reset state
        #2;
        chk("rst io_req", io_req, 0);
        chk("rst mem_valid", mem_valid, 0);
        chk("rst mem_rdata", mem_rdata, 0);
        chk("rst err", err, 0);
        chk("rst mem_ready", mem_ready, 1);
        chk("rst ram_en", ram_en, 0);
        tick();
        rst = 1'b0;

        // RAM vectors
        for (int i = 0; i < 11; i++) begin
            tick();
            drive(vecs[i].addr, vecs[i].oe, vecs[i].we, vecs[i].wdata);
            @(negedge clk);
            chk($sformatf("v%0d ready", i), mem_ready, 1);
            chk($sformatf("v%0d ram_en", i), ram_en, vecs[i].exp_en);
            chk($sformatf("v%0d ram_we", i), ram_we, vecs[i].exp_we);
            if (vecs[i].exp_en)
                chk($sformatf("v%0d ram_addr", i), ram_addr, {18'h0, vecs[i].addr[15:2]});
            if (vecs[i].exp_en && vecs[i].we != 4'h0)
                chk($sformatf("v%0d ram_wdata", i), ram_wdata, vecs[i].exp_wdata);
            tick();
            idle_inputs();
            @(negedge clk);
            chk($sformatf("v%0d mem_valid", i), mem_valid, (vecs[i].we == 4'h0) ? 1 : 0);
            if (vecs[i].we == 4'h0)
                chk($sformatf("v%0d mem_rdata", i), mem_rdata, vecs[i].exp_rdata);
            tick();
            @(negedge clk);
            chk($sformatf("v%0d valid_drop", i), mem_valid, 0);
            chk($sformatf("v%0d err", i), err, vecs[i].exp_err);
        end

        // Reset clears sticky error
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("err cleared", err, 0);

        // IO load acked after 5 wait cycles
        tick();
        drive(32'h80000004, 4'hF, 4'h0, 32'h0);
        @(negedge clk);
        chk("io ld ram_en", ram_en, 0);
        tick();
        idle_inputs();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("io ld wait%0d req", k), io_req, 1);
            chk($sformatf("io ld wait%0d ready", k), mem_ready, 0);
            chk($sformatf("io ld wait%0d valid", k), mem_valid, 0);
            tick();
        end
        chk("io ld addr", io_addr, 32'h80000004);
        chk("io ld we", io_we, 0);
        io_ack = 1'b1; io_rdata = 32'hCAFEF00D;
        tick();
        io_ack = 1'b0; io_rdata = 32'h0;
        @(negedge clk);
        chk("io ld valid", mem_valid, 1);
        chk("io ld rdata", mem_rdata, 32'hCAFEF00D);
        chk("io ld req_drop", io_req, 0);
        chk("io ld ready_resp", mem_ready, 0);
        tick();
        @(negedge clk);
        chk("io ld valid_drop", mem_valid, 0);
        chk("io ld ready_back", mem_ready, 1);

        // IO byte store: lane-aligned enables/data, no mem_valid
        tick();
        drive(32'h80000011, 4'h1, 4'h1, 32'h0000005A);
        tick();
        idle_inputs();
        @(negedge clk);
        chk("io sb req", io_req, 1);
        chk("io sb we", io_we, 4'b0010);
        chk("io sb wdata", io_wdata, 32'h00005A00);
        chk("io sb addr", io_addr, 32'h80000011);
        tick();
        io_ack = 1'b1;
        tick();
        io_ack = 1'b0;
        @(negedge clk);
        chk("io sb req_drop", io_req, 0);
        chk("io sb no_valid", mem_valid, 0);
        chk("io sb ready", mem_ready, 1);

        // Ack arriving exactly on the final count is a success
        tick();
        drive(32'h80000020, 4'hF, 4'h0, 32'h0);
        tick();
        idle_inputs();
        hi = 0;
        for (int k = 0; k < 255; k++) begin
            if (io_req) hi++;
            tick();
        end
        chk("edge req_held", hi, 255);
        io_ack = 1'b1; io_rdata = 32'h12345678;
        @(negedge clk);
        chk("edge req_last", io_req, 1);
        tick();
        io_ack = 1'b0; io_rdata = 32'h0;
        @(negedge clk);
        chk("edge valid", mem_valid, 1);
        chk("edge rdata", mem_rdata, 32'h12345678);
        chk("edge err", err, 0);

        // Timeout: io_req held for counts 0..IO_TIMEOUT, then DEADBEEF and err
        tick();
        tick();
        drive(32'h80000008, 4'hF, 4'h0, 32'h0);
        tick();
        idle_inputs();
        n = 0;
        while (io_req && n < 400) begin
            n++;
            tick();
        end
        chk("tmo req_cycles", n, 255 + 1);
        @(negedge clk);
        chk("tmo valid", mem_valid, 1);
        chk("tmo rdata", mem_rdata, 32'hDEADBEEF);
        chk("tmo err", err, 1);
        repeat (3) tick();
        @(negedge clk);
        chk("tmo valid_drop", mem_valid, 0);
        chk("tmo err_sticky", err, 1);

        // Reset in the middle of IO_WAIT
        tick();
        drive(32'h80000004, 4'hF, 4'h0, 32'h0);
        tick();
        idle_inputs();
        repeat (2) tick();
        @(negedge clk);
        chk("mid io_req_before", io_req, 1);
        rst = 1'b1;
        drive(32'h100, 4'hF, 4'h0, 32'h0);
        #1;
        chk("mid io_req", io_req, 0);
        chk("mid ready", mem_ready, 1);
        chk("mid err", err, 0);
        chk("mid valid", mem_valid, 0);
        chk("mid ram_en", ram_en, 0);
        chk("mid ram_we", ram_we, 0);
        idle_inputs();
        tick();
        rst = 1'b0;
        io_ack = 1'b1;
        tick();
        io_ack = 1'b0;
        hi = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (mem_valid || io_req) hi++;
            tick();
        end
        chk("mid quiet", hi, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
